// File: rtl/motor_pwm_driver.sv
// H-bridge PWM driver: turns a 2-bit motor command into IN1/IN2 drive with a
// per-period soft-start duty ramp and a forced coast interval on reversals.
module motor_pwm_driver #(
  parameter int unsigned PWM_PERIOD = 1000,
  parameter int unsigned DUTY_MAX   = 700,
  parameter int unsigned RAMP_STEP  = 10,
  parameter int unsigned DEADTIME   = 2000
) (
  input  logic       clkus,
  input  logic       rst,
  input  logic [1:0] motor,
  output logic       in1,
  output logic       in2,
  output logic       ramp_done,
  output logic       dead_active
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FWD,
    S_REV,
    S_BRAKE,
    S_DEAD
  } state_t;

  localparam logic [15:0] PCNT_LAST = 16'(PWM_PERIOD - 1);
  localparam logic [15:0] DUTY_SAT  = 16'(DUTY_MAX);
  localparam logic [15:0] DEAD_LOAD = 16'(DEADTIME - 1);
  localparam logic [16:0] STEP_W    = 17'(RAMP_STEP);
  localparam logic [16:0] DUTY_W    = 17'(DUTY_MAX);

  state_t      state_q, state_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic [15:0] duty_q, duty_d;
  logic [15:0] dcnt_q, dcnt_d;
  logic        in1_q, in1_d;
  logic        in2_q, in2_d;
  logic        ramp_done_q, ramp_done_d;
  logic        dead_active_q, dead_active_d;

  logic        wrap;
  logic [16:0] duty_sum;
  logic        driving_d;

  assign wrap     = (pcnt_q == PCNT_LAST);
  assign duty_sum = {1'b0, duty_q} + STEP_W;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        case (motor)
          2'b01:   state_d = S_FWD;
          2'b10:   state_d = S_REV;
          2'b11:   state_d = S_BRAKE;
          default: state_d = S_IDLE;
        endcase
      end
      S_FWD: begin
        case (motor)
          2'b00:   state_d = S_IDLE;
          2'b10:   state_d = S_DEAD;
          2'b11:   state_d = S_BRAKE;
          default: state_d = S_FWD;
        endcase
      end
      S_REV: begin
        case (motor)
          2'b00:   state_d = S_IDLE;
          2'b01:   state_d = S_DEAD;
          2'b11:   state_d = S_BRAKE;
          default: state_d = S_REV;
        endcase
      end
      S_BRAKE: begin
        case (motor)
          2'b00:   state_d = S_IDLE;
          2'b01:   state_d = S_FWD;
          2'b10:   state_d = S_REV;
          default: state_d = S_BRAKE;
        endcase
      end
      S_DEAD: begin
        // Any non-coast command, even back to the original direction, waits out the full interval
        if (motor == 2'b00) begin
          state_d = S_IDLE;
        end else if (dcnt_q == 16'd0) begin
          case (motor)
            2'b01:   state_d = S_FWD;
            2'b10:   state_d = S_REV;
            default: state_d = S_BRAKE;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pcnt_d    = wrap ? 16'd0 : pcnt_q + 16'd1;
    driving_d = (state_d == S_FWD) || (state_d == S_REV);

    dcnt_d = 16'd0;
    if (state_d == S_DEAD) begin
      dcnt_d = (state_q == S_DEAD) ? dcnt_q - 16'd1 : DEAD_LOAD;
    end

    // Entering a drive state from anywhere restarts the ramp from zero
    duty_d = 16'd0;
    if (driving_d && (state_d == state_q)) begin
      if (wrap) begin
        duty_d = (duty_sum > DUTY_W) ? DUTY_SAT : duty_sum[15:0];
      end else begin
        duty_d = duty_q;
      end
    end

    in1_d         = ((state_q == S_FWD) && (pcnt_q < duty_q)) || (state_q == S_BRAKE);
    in2_d         = ((state_q == S_REV) && (pcnt_q < duty_q)) || (state_q == S_BRAKE);
    ramp_done_d   = ((state_q == S_FWD) || (state_q == S_REV)) && (duty_q == DUTY_SAT);
    dead_active_d = (state_q == S_DEAD);
  end

  always_ff @(posedge clkus or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      pcnt_q        <= 16'd0;
      duty_q        <= 16'd0;
      dcnt_q        <= 16'd0;
      in1_q         <= 1'b0;
      in2_q         <= 1'b0;
      ramp_done_q   <= 1'b0;
      dead_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pcnt_q        <= pcnt_d;
      duty_q        <= duty_d;
      dcnt_q        <= dcnt_d;
      in1_q         <= in1_d;
      in2_q         <= in2_d;
      ramp_done_q   <= ramp_done_d;
      dead_active_q <= dead_active_d;
    end
  end

  assign in1         = in1_q;
  assign in2         = in2_q;
  assign ramp_done   = ramp_done_q;
  assign dead_active = dead_active_q;

endmodule
